// File: rtl/mcl_seq_pkg.sv
// Shared encodings for the microcode sequencer:
// jump source codes, condition field layout, FSM states.
package mcl_seq_pkg;

  typedef enum logic [2:0] {
    SRC_IMM  = 3'd0,
    SRC_DISP = 3'd1,
    SRC_RET  = 3'd2,
    SRC_REP  = 3'd3,
    SRC_IDX  = 3'd4
  } jmp_src_e;

  localparam int COND_SEL_W  = 4;
  localparam int COND_INV_IX = 4;

  typedef struct packed {
    logic                  inv;
    logic [COND_SEL_W-1:0] sel;
  } jmp_cond_t;

  typedef enum logic {
    ST_RUN,
    ST_BUBBLE
  } seq_state_e;

endpackage

// File: rtl/mcl_call_stack.sv
// Return-address stack; entry 0 is the top.
// A full push drops the oldest entry; flags are sticky.
module mcl_call_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);

  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] lvl_q;
  logic          full;
  logic          push_only;
  logic          pop_only;

  assign full      = lvl_q == LW'(DEPTH);
  assign empty     = lvl_q == '0;
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign top       = mem[0];
  assign level     = lvl_q;

  always_ff @(posedge clk) begin
    if (push_only) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        mem[i] <= mem[i-1];
    end else if (pop_only) begin
      for (int i = 0; i < DEPTH-1; i++)
        mem[i] <= mem[i+1];
    end else if (push & pop) begin
      mem[0] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push_only && !full)
        lvl_q <= lvl_q + LW'(1);
      else if (pop_only && !empty)
        lvl_q <= lvl_q - LW'(1);
      // an error in the clearing cycle must survive
      ovf <= (push_only & full) | (ovf & ~clr);
      unf <= (pop_only & empty) | (unf & ~clr);
    end
  end

endmodule

// File: rtl/mcl_sequencer.sv
// Microcode address sequencer: next-address select,
// one-cycle bubble after taken jumps, return stack.
module mcl_sequencer
  import mcl_seq_pkg::*;
#(
  parameter int                ADDR_W       = 11,
  parameter int                STACK_DEPTH  = 4,
  parameter int                NUM_COND     = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 'h7D0
) (
  input  logic                               CORE_CLK,
  input  logic                               RESET_n,
  input  logic                               HOLD,
  input  logic                               JMP_EN,
  input  logic [2:0]                         JMP_SRC,
  input  logic                               JMP_CALL,
  input  logic [4:0]                         JMP_COND,
  input  logic [ADDR_W-1:0]                  JMP_IMM,
  input  logic [7:0]                         DISPATCH,
  input  logic [NUM_COND-1:0]                COND,
  input  logic                               CLR_ERR,
  output logic [ADDR_W-1:0]                  ROM_ADDR,
  output logic                               STALL,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   STACK_LEVEL,
  output logic                               STACK_OVF,
  output logic                               STACK_UNF
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tgt, seq_addr, top;
  jmp_cond_t         jc;
  jmp_src_e          src;
  logic [15:0]       cvec;
  logic              sel_ok, cond_hit, src_ok;
  logic              take, push, pop, empty;

  assign jc       = jmp_cond_t'(JMP_COND);
  assign src      = jmp_src_e'(JMP_SRC);
  // slot 0 is the always-true condition
  assign cvec     = 16'({COND, 1'b1});
  assign sel_ok   = {1'b0, jc.sel} <= 5'(NUM_COND);
  assign cond_hit = sel_ok & (cvec[jc.sel] ^ jc.inv);
  assign src_ok   = JMP_SRC <= 3'd4;
  assign take     = JMP_EN & src_ok & cond_hit
                  & (state_q == ST_RUN) & ~HOLD;
  assign push     = take & JMP_CALL;
  assign pop      = take & (src == SRC_RET);
  assign seq_addr = addr_q + ADDR_W'(1);

  always_comb begin
    tgt = seq_addr;
    unique case (src)
      SRC_IMM:  tgt = JMP_IMM;
      SRC_DISP: tgt = ADDR_W'(DISPATCH);
      SRC_RET:  tgt = empty ? RESET_VECTOR : top;
      SRC_REP:  tgt = addr_q - ADDR_W'(1);
      SRC_IDX:  tgt = JMP_IMM + ADDR_W'(DISPATCH);
      default:  tgt = seq_addr;
    endcase
  end

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_RUN;
      addr_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (!HOLD) begin
      addr_d  = take ? tgt : seq_addr;
      state_d = take ? ST_BUBBLE : ST_RUN;
    end
  end

  always_comb begin
    ROM_ADDR = addr_q;
    STALL    = state_q == ST_BUBBLE;
  end

  mcl_call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (CORE_CLK),
    .rst_n (RESET_n),
    .push  (push),
    .pop   (pop),
    .clr   (CLR_ERR),
    .din   (addr_q),
    .top   (top),
    .level (STACK_LEVEL),
    .empty (empty),
    .ovf   (STACK_OVF),
    .unf   (STACK_UNF)
  );

endmodule

// File: tb/tb_mcl_sequencer.sv
// Bench for mcl_sequencer: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_mcl_sequencer;

  localparam logic [10:0] RV = 11'h7D0;
  localparam int DEPTH = 4;

  logic        CORE_CLK = 1'b0;
  logic        RESET_n  = 1'b0;
  logic        HOLD     = 1'b0;
  logic        JMP_EN   = 1'b0;
  logic [2:0]  JMP_SRC  = 3'd0;
  logic        JMP_CALL = 1'b0;
  logic [4:0]  JMP_COND = 5'd0;
  logic [10:0] JMP_IMM  = 11'd0;
  logic [7:0]  DISPATCH = 8'd0;
  logic [7:0]  COND     = 8'd0;
  logic        CLR_ERR  = 1'b0;
  logic [10:0] ROM_ADDR;
  logic        STALL;
  logic [2:0]  STACK_LEVEL;
  logic        STACK_OVF;
  logic        STACK_UNF;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  mcl_sequencer #(
    .ADDR_W       (11),
    .STACK_DEPTH  (DEPTH),
    .NUM_COND     (8),
    .RESET_VECTOR (RV)
  ) dut (
    .CORE_CLK    (CORE_CLK),
    .RESET_n     (RESET_n),
    .HOLD        (HOLD),
    .JMP_EN      (JMP_EN),
    .JMP_SRC     (JMP_SRC),
    .JMP_CALL    (JMP_CALL),
    .JMP_COND    (JMP_COND),
    .JMP_IMM     (JMP_IMM),
    .DISPATCH    (DISPATCH),
    .COND        (COND),
    .CLR_ERR     (CLR_ERR),
    .ROM_ADDR    (ROM_ADDR),
    .STALL       (STALL),
    .STACK_LEVEL (STACK_LEVEL),
    .STACK_OVF   (STACK_OVF),
    .STACK_UNF   (STACK_UNF)
  );

  always #5 CORE_CLK = ~CORE_CLK;

  task automatic chk(string name, int unsigned act,
                     int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // reference model
  logic [10:0] m_addr = RV;
  bit          m_stall = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic [10:0] m_stk[$];
  logic [10:0] nx;
  bit          tk, e_o, e_u;

  function automatic bit cond_ok(logic [4:0] jc,
                                 logic [7:0] c);
    int sel;
    bit v;
    sel = int'(jc[3:0]);
    if (sel > 8) return 1'b0;
    v = (sel == 0) ? 1'b1 : c[sel-1];
    return v ^ jc[4];
  endfunction

  always @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      m_addr  = RV;
      m_stall = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_stk.delete();
    end else begin
      e_o = 1'b0;
      e_u = 1'b0;
      if (!HOLD) begin
        tk = JMP_EN && !m_stall && JMP_SRC <= 3'd4
             && cond_ok(JMP_COND, COND);
        nx = m_addr + 11'd1;
        if (tk) begin
          case (JMP_SRC)
            3'd0: nx = JMP_IMM;
            3'd1: nx = {3'b000, DISPATCH};
            3'd2: nx = (m_stk.size() == 0) ? RV : m_stk[0];
            3'd3: nx = m_addr - 11'd1;
            default: nx = JMP_IMM + {3'b000, DISPATCH};
          endcase
          if (JMP_SRC == 3'd2 && JMP_CALL) begin
            if (m_stk.size() > 0) m_stk[0] = m_addr;
          end else if (JMP_SRC == 3'd2) begin
            if (m_stk.size() == 0) e_u = 1'b1;
            else void'(m_stk.pop_front());
          end else if (JMP_CALL) begin
            if (m_stk.size() == DEPTH) begin
              void'(m_stk.pop_back());
              e_o = 1'b1;
            end
            m_stk.push_front(m_addr);
          end
        end
        m_addr  = nx;
        m_stall = tk;
      end
      m_ovf = e_o || (m_ovf && !CLR_ERR);
      m_unf = e_u || (m_unf && !CLR_ERR);
    end
  end

  always @(negedge CORE_CLK) begin
    if (chk_en) begin
      chk("m_addr",  ROM_ADDR,    m_addr);
      chk("m_stall", STALL,       m_stall);
      chk("m_level", STACK_LEVEL, m_stk.size());
      chk("m_ovf",   STACK_OVF,   m_ovf);
      chk("m_unf",   STACK_UNF,   m_unf);
    end
  end

  task automatic step();
    @(negedge CORE_CLK);
  endtask

  task automatic lit(string name, int unsigned a,
                     int unsigned s);
    chk({name, "_addr"},  ROM_ADDR, a);
    chk({name, "_stall"}, STALL,    s);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_addr",  ROM_ADDR,    11'h7D0);
    chk("rst_stall", STALL,       1'b0);
    chk("rst_level", STACK_LEVEL, 0);
    chk("rst_flags", {STACK_OVF, STACK_UNF}, 0);
    RESET_n = 1'b1;
    chk_en  = 1'b1;
    step(); lit("seq1", 11'h7D1, 0);
    step(); lit("seq2", 11'h7D2, 0);

    JMP_EN = 1; JMP_SRC = 3'd1; DISPATCH = 8'hA9;
    step(); lit("disp", 11'h0A9, 1);
    step(); lit("disp_nx", 11'h0AA, 0);

    JMP_SRC = 3'd0; JMP_IMM = 11'h123; JMP_COND = 5'h03;
    step(); lit("cond_nt", 11'h0AB, 0);
    JMP_COND = 5'h13;
    step(); lit("cond_inv", 11'h123, 1);
    JMP_COND = 5'h19;
    step(); lit("cond_bub", 11'h124, 0);
    step(); lit("cond_oor", 11'h125, 0);

    JMP_SRC = 3'd4; JMP_IMM = 11'h7F0; DISPATCH = 8'h20;
    JMP_COND = 5'h00;
    step(); lit("idx_wrap", 11'h010, 1);
    JMP_EN = 0;
    step();
    JMP_EN = 1; JMP_SRC = 3'd5;
    step(); lit("rsvd", 11'h012, 0);

    JMP_SRC = 3'd0; JMP_CALL = 1;
    for (int k = 1; k <= 5; k++) begin
      JMP_EN = 1; JMP_IMM = 11'(k * 'h100);
      step();
      JMP_EN = 0;
      step();
    end
    chk("ovf_level", STACK_LEVEL, 4);
    chk("ovf_flag",  STACK_OVF,   1);

    JMP_CALL = 0; JMP_SRC = 3'd2;
    for (int k = 4; k >= 1; k--) begin
      JMP_EN = 1;
      step(); lit("ret", 11'(k * 'h100 + 1), 1);
      JMP_EN = 0;
      step();
    end
    chk("ret_level", STACK_LEVEL, 0);
    JMP_EN = 1; CLR_ERR = 1;
    step(); lit("unf", 11'h7D0, 1);
    chk("unf_flag", STACK_UNF, 1);
    chk("unf_ovfclr", STACK_OVF, 0);
    JMP_EN = 0; CLR_ERR = 0;
    step();
    CLR_ERR = 1;
    step(); chk("unf_clr", STACK_UNF, 0);
    CLR_ERR = 0;

    JMP_SRC = 3'd0; JMP_CALL = 1; JMP_IMM = 11'h600;
    JMP_EN = 1;
    step(); lit("call6", 11'h600, 1);
    JMP_EN = 0;
    step();
    JMP_SRC = 3'd2; JMP_EN = 1;
    step(); lit("retcall", 11'h7D2, 1);
    chk("retcall_lvl", STACK_LEVEL, 1);
    JMP_EN = 0; JMP_CALL = 0;
    step();
    JMP_EN = 1;
    step(); lit("ret_repl", 11'h601, 1);
    JMP_EN = 0;
    step(); lit("ret_nx", 11'h602, 0);

    JMP_SRC = 3'd3; JMP_COND = 5'h11; COND = 8'h00;
    JMP_EN = 1;
    for (int k = 0; k < 3; k++) begin
      step(); lit("rep", 11'h601, 1);
      step(); lit("rep_b", 11'h602, 0);
    end
    COND = 8'h01;
    step(); lit("rep_end", 11'h603, 0);

    HOLD = 1; JMP_SRC = 3'd0; JMP_COND = 5'h00;
    JMP_IMM = 11'h055;
    for (int k = 0; k < 3; k++) begin
      step(); lit("hold", 11'h603, 0);
    end
    HOLD = 0; JMP_CALL = 1;
    step(); lit("jmp55", 11'h055, 1);
    chk("jmp55_lvl", STACK_LEVEL, 1);
    JMP_EN = 0; JMP_CALL = 0;
    #2 RESET_n = 1'b0;
    #1;
    chk("mrst_addr",  ROM_ADDR,    11'h7D0);
    chk("mrst_stall", STALL,       0);
    chk("mrst_level", STACK_LEVEL, 0);
    chk("mrst_flags", {STACK_OVF, STACK_UNF}, 0);
    step();
    RESET_n = 1'b1;
    step(); lit("mrst_seq", 11'h7D1, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
